// File: rtl/booth_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : booth_result_checker
//  Purpose  : Checks the products coming out of the radix-4 Booth multiplier
//             stage. For each accepted (operand, product) pair it recomputes
//             the signed product with a serial shift-add engine, one multiplier
//             bit per cycle. It then scores the pair as a pass or an error and
//             raises 'finish' for FINISH_HOLD cycles so the upstream stage can
//             advance its operand.
//  Ports    : clk              rising-edge clock
//             rst              asynchronous active-high reset
//             in_valid_i       operand/result pair present
//             in_ready_o       checker idle, pair accepted when valid
//             in_operand_i     signed multiplier (WIDTH)
//             in_result_i      signed product to check (2*WIDTH)
//             finish_o         check done, held FINISH_HOLD cycles
//             mismatch_o       sticky, any compare failed since reset
//             pass_cnt_o       saturating count of matches
//             err_cnt_o        saturating count of mismatches
//             last_expected_o  reference product of the most recent check
//  Revision : 1.0  initial release
// ============================================================================
module booth_result_checker #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] MULTIPLICAND = 32'h55555555,
   parameter int               FINISH_HOLD  = 4,
   parameter int               CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_operand_i,
   input  logic [2*WIDTH-1:0]   in_result_i,
   output logic                 finish_o,
   output logic                 mismatch_o,
   output logic [CNT_W-1:0]     pass_cnt_o,
   output logic [CNT_W-1:0]     err_cnt_o,
   output logic [2*WIDTH-1:0]   last_expected_o
);

   localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HOLD_W = (FINISH_HOLD > 1) ? $clog2(FINISH_HOLD) : 1;
   localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(WIDTH - 1);
   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(FINISH_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_CMP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   r_q, r_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 finish_q, finish_d;
   logic                 mismatch_q, mismatch_d;
   logic [CNT_W-1:0]     pass_q, pass_d;
   logic [CNT_W-1:0]     err_q, err_d;
   logic [2*WIDTH-1:0]   last_q, last_d;

   // Multiplicand sign-extended to product width, shifted to the weight of
   // the multiplier bit currently being processed.
   logic [2*WIDTH-1:0]   w_a;
   logic [2*WIDTH-1:0]   w_addend;

   assign w_a      = {{WIDTH{MULTIPLICAND[WIDTH-1]}}, MULTIPLICAND};
   assign w_addend = w_a << idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         b_q        <= '0;
         r_q        <= '0;
         idx_q      <= '0;
         hold_q     <= '0;
         finish_q   <= 1'b0;
         mismatch_q <= 1'b0;
         pass_q     <= '0;
         err_q      <= '0;
         last_q     <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         r_q        <= r_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         finish_q   <= finish_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         last_q     <= last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      b_d        = b_q;
      r_d        = r_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      finish_d   = finish_q;
      mismatch_d = mismatch_q;
      pass_d     = pass_q;
      err_d      = err_q;
      last_d     = last_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               b_d     = in_operand_i;
               r_d     = in_result_i;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            // The top multiplier bit carries negative weight in two's
            // complement, so it subtracts instead of adding.
            if (b_q[idx_q]) begin
               if (idx_q == c_LAST_IDX) begin
                  acc_d = acc_q - w_addend;
               end else begin
                  acc_d = acc_q + w_addend;
               end
            end
            if (idx_q == c_LAST_IDX) begin
               state_d = S_CMP;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_CMP: begin
            last_d = acc_q;
            if (acc_q == r_q) begin
               if (pass_q != '1) begin
                  pass_d = pass_q + 1'b1;
               end
            end else begin
               if (err_q != '1) begin
                  err_d = err_q + 1'b1;
               end
               mismatch_d = 1'b1;
            end
            finish_d = 1'b1;
            hold_d   = '0;
            state_d  = S_FIN;
         end

         S_FIN: begin
            if (hold_q == c_HOLD_LAST) begin
               finish_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready_o      = (state_q == S_IDLE);
   assign finish_o        = finish_q;
   assign mismatch_o      = mismatch_q;
   assign pass_cnt_o      = pass_q;
   assign err_cnt_o       = err_q;
   assign last_expected_o = last_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_result_checker
//  Purpose  : Self-checking bench for booth_result_checker. It drives a
//             vector table, hand sequences for the busy/reset corners, a
//             saturating CNT_W=2 instance and random operands. All of these
//             are compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_booth_result_checker;

   localparam int W    = 32;
   localparam int HOLD = 4;
   localparam logic signed [W-1:0] MC = 32'h55555555;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Instance 0: CNT_W=16, instance 1: CNT_W=2
   logic          v0 = 1'b0, v1 = 1'b0;
   logic [W-1:0]  op0 = '0, op1 = '0;
   logic [63:0]   res0 = '0, res1 = '0;
   logic          rdy0, rdy1, fin0, fin1, mm0, mm1;
   logic [15:0]   pc0, ec0;
   logic [1:0]    pc1, ec1;
   logic [63:0]   last0, last1;

   int errors = 0;
   int checks = 0;

   // Reference model state per instance
   int  m_pass [2];
   int  m_err  [2];
   bit  m_mm   [2];
   int  m_max  [2];

   always #5 clk = ~clk;

   booth_result_checker #(.WIDTH(W), .MULTIPLICAND(32'h55555555),
                          .FINISH_HOLD(HOLD), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid_i(v0), .in_ready_o(rdy0),
      .in_operand_i(op0), .in_result_i(res0), .finish_o(fin0),
      .mismatch_o(mm0), .pass_cnt_o(pc0), .err_cnt_o(ec0),
      .last_expected_o(last0));

   booth_result_checker #(.WIDTH(W), .MULTIPLICAND(32'h55555555),
                          .FINISH_HOLD(HOLD), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid_i(v1), .in_ready_o(rdy1),
      .in_operand_i(op1), .in_result_i(res1), .finish_o(fin1),
      .mismatch_o(mm1), .pass_cnt_o(pc1), .err_cnt_o(ec1),
      .last_expected_o(last1));

   typedef struct packed {
      logic [W-1:0] op;
      logic [63:0]  res;
      logic         pass;
      logic [63:0]  last;
   } vec_t;

   vec_t tbl [7];

   function automatic logic [63:0] ref_product(input logic [W-1:0] b);
      longint p;
      p = longint'(signed'(b)) * longint'(MC);
      return 64'(p);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [W-1:0] op, input logic [63:0] res);
      if (sel == 0) begin v0 = v; op0 = op; res0 = res; end
      else          begin v1 = v; op1 = op; res1 = res; end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pass[i] = 0; m_err[i] = 0; m_mm[i] = 1'b0;
      end
   endtask

   task automatic check_outputs(input int sel, input string tag);
      if (sel == 0) begin
         chk({tag, " pass_cnt"}, 64'(pc0), 64'(m_pass[0]));
         chk({tag, " err_cnt"},  64'(ec0), 64'(m_err[0]));
         chk({tag, " mismatch"}, 64'(mm0), 64'(m_mm[0]));
      end else begin
         chk({tag, " pass_cnt"}, 64'(pc1), 64'(m_pass[1]));
         chk({tag, " err_cnt"},  64'(ec1), 64'(m_err[1]));
         chk({tag, " mismatch"}, 64'(mm1), 64'(m_mm[1]));
      end
   endtask

   // One complete check transaction with cycle-exact finish/ready checking.
   // 'pulse' re-asserts in_valid with a bogus pair during CALC.
   task automatic run_check(input int sel, input logic [W-1:0] op, input logic [63:0] res,
                            input logic exp_pass, input logic [63:0] exp_last,
                            input logic pulse, input string tag);
      int  budget;
      int  tbad;
      logic f, r;
      budget = 0;
      while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && budget < 200) begin
         @(posedge clk); #1; budget++;
      end
      if (budget >= 200) chk({tag, " ready timeout"}, 64'd0, 64'd1);
      @(negedge clk);
      drive(sel, 1'b1, op, res);
      @(posedge clk); #1;                 // accept edge (cycle 0)
      drive(sel, 1'b0, op, res);
      tbad = 0;
      for (int k = 1; k <= W + HOLD + 1; k++) begin
         @(posedge clk); #1;
         f = (sel == 0) ? fin0 : fin1;
         r = (sel == 0) ? rdy0 : rdy1;
         if (f !== ((k >= W + 1) && (k <= W + HOLD))) tbad++;
         if (r !== (k == W + HOLD + 1)) tbad++;
         if (pulse && k == 5) drive(sel, 1'b1, ~op, res + 64'd1);
         if (pulse && k == 6) drive(sel, 1'b0, op, res);
      end
      chk({tag, " finish/ready timing errors"}, 64'(tbad), 64'd0);
      if (exp_pass) begin
         if (m_pass[sel] < m_max[sel]) m_pass[sel]++;
      end else begin
         if (m_err[sel] < m_max[sel]) m_err[sel]++;
         m_mm[sel] = 1'b1;
      end
      chk({tag, " last_expected"}, (sel == 0) ? last0 : last1, exp_last);
      check_outputs(sel, tag);
   endtask

   initial begin
      int fin_seen;
      int budget;
      logic [W-1:0] rop;
      logic [63:0]  rexp, rres;
      bit           corrupt;

      m_max[0] = 65535;
      m_max[1] = 3;
      model_reset();

      tbl[0] = '{32'h00000000, 64'h00000000_00000000, 1'b1, 64'h00000000_00000000};
      tbl[1] = '{32'h00000003, 64'h00000000_FFFFFFFF, 1'b1, 64'h00000000_FFFFFFFF};
      tbl[2] = '{32'hFFFFFFFF, 64'hFFFFFFFF_AAAAAAAB, 1'b1, 64'hFFFFFFFF_AAAAAAAB};
      tbl[3] = '{32'hFFFFFFFF, 64'h00000000_00000000, 1'b0, 64'hFFFFFFFF_AAAAAAAB};
      tbl[4] = '{32'h80000000, 64'hD5555555_80000000, 1'b1, 64'hD5555555_80000000};
      tbl[5] = '{32'h7FFFFFFF, 64'h2AAAAAAA_2AAAAAAB, 1'b1, 64'h2AAAAAAA_2AAAAAAB};
      tbl[6] = '{32'h00000001, 64'h00000000_55555555, 1'b1, 64'h00000000_55555555};

      // Reset and idle behaviour
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("reset in_ready", 64'(rdy0), 64'd1);
      chk("reset finish", 64'(fin0), 64'd0);
      chk("reset last_expected", last0, 64'd0);
      check_outputs(0, "reset");
      fin_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (fin0 !== 1'b0 || fin1 !== 1'b0) fin_seen++;
      end
      chk("idle finish never asserts", 64'(fin_seen), 64'd0);

      // Table vectors; the mismatch entry is followed by passes so the
      // sticky flag is exercised. Entry 1 also pulses in_valid mid-CALC.
      for (int i = 0; i < 7; i++) begin
         run_check(0, tbl[i].op, tbl[i].res, tbl[i].pass, tbl[i].last,
                   (i == 1), $sformatf("vec%0d", i));
      end

      // Held in_valid: not accepted while FIN ends, accepted on the next edge
      @(negedge clk);
      drive(0, 1'b1, 32'h00000001, 64'h00000000_55555555);
      @(posedge clk); #1;
      for (int k = 1; k <= W + HOLD + 2; k++) begin
         @(posedge clk); #1;
         if (k == W + HOLD + 1) chk("held valid ready at FIN exit", 64'(rdy0), 64'd1);
         if (k == W + HOLD + 2) chk("held valid re-accepted", 64'(rdy0), 64'd0);
      end
      drive(0, 1'b0, 32'h0, 64'h0);
      budget = 0;
      while (rdy0 !== 1'b1 && budget < 200) begin
         @(posedge clk); #1; budget++;
      end
      chk("held valid completion", 64'(budget < 200), 64'd1);
      m_pass[0] += 2;
      check_outputs(0, "held valid");

      // Reset in the middle of CALC
      @(negedge clk);
      drive(0, 1'b1, 32'h00000005, 64'h0);
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0, 64'h0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("midreset in_ready", 64'(rdy0), 64'd1);
      chk("midreset finish", 64'(fin0), 64'd0);
      chk("midreset last_expected", last0, 64'd0);
      check_outputs(0, "midreset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Saturating instance: five matches, pass count stops at 3
      for (int i = 0; i < 5; i++) begin
         run_check(1, 32'h00000001, 64'h00000000_55555555, 1'b1,
                   64'h00000000_55555555, 1'b0, $sformatf("sat%0d", i));
      end
      run_check(1, 32'h00000002, 64'h0, 1'b0, 64'h00000000_AAAAAAAA, 1'b0, "sat err");

      // Random operands against the arithmetic model
      for (int i = 0; i < 10; i++) begin
         rop     = $urandom;
         rexp    = ref_product(rop);
         corrupt = (i >= 5) && ($urandom_range(2) == 0);
         rres    = corrupt ? (rexp ^ (64'd1 << $urandom_range(63))) : rexp;
         run_check(0, rop, rres, !corrupt, rexp, 1'b0, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
